// File: rtl/diff_demo_pkg.sv
// Shared types and default sizing for the diff-NN datapath blocks.
package diff_demo_pkg;

    localparam int unsigned KMAX_DEF       = 5;
    localparam int unsigned PSUM_WIDTH_DEF = 20;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } pe_conv_state_t;

endpackage

// File: rtl/pe_out_fifo.sv
// Synchronous show-ahead FIFO: head entry is visible on rdata_o while valid_o is high.
module pe_out_fifo #(
    parameter int unsigned WIDTH = 21,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    // Guard against overflow/underflow locally so a misbehaving producer cannot corrupt state.
    always_comb begin
        push_ok = push_i && (count_q != CW'(DEPTH));
        pop_ok  = pop_i && (count_q != '0);
    end

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Show-ahead read port.
    always_comb begin
        rdata_o = mem_q[rd_ptr_q];
        valid_o = (count_q != '0);
        count_o = count_q;
    end

endmodule

// File: rtl/pe_row_conv.sv
// Row-convolution PE: runtime kernel size, transposed MAC chain, output FIFO.
// Optional build macro PE_SATURATE_EN: chain additions clamp instead of wrapping.
module pe_row_conv
    import diff_demo_pkg::*;
#(
    parameter int unsigned KMAX       = KMAX_DEF,
    parameter int unsigned ACT_WIDTH  = 8,
    parameter int unsigned W_WIDTH    = 8,
    parameter int unsigned PSUM_WIDTH = PSUM_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start_i,
    input  logic                              stop_i,
    input  logic [$clog2(KMAX+1)-1:0]         cfg_k_i,
    input  logic                              cfg_signed_i,
    input  logic                              w_load_i,
    input  logic [KMAX*W_WIDTH-1:0]           w_data_i,
    input  logic                              act_valid_i,
    output logic                              act_ready_o,
    input  logic [ACT_WIDTH-1:0]              act_data_i,
    input  logic                              act_last_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [PSUM_WIDTH-1:0]             out_data_o,
    output logic                              out_last_o,
    output logic                              busy_o,
    output logic                              short_row_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o
);

    localparam int unsigned KW = $clog2(KMAX + 1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned P  = PSUM_WIDTH;
    localparam int unsigned A  = ACT_WIDTH;
    localparam int unsigned W  = W_WIDTH;
    // Product table padded to a power of two so the runtime tap index is full width.
    localparam int unsigned NP = 2 ** KW;
    localparam int unsigned SN = (KMAX > 1) ? KMAX - 1 : 1;

    pe_conv_state_t     state_q;
    logic [KW-1:0]      k_q;
    logic               signed_q;
    logic [KMAX*W-1:0]  w_q;
    logic               short_row_q;
    logic [KW-1:0]      col_q;
    logic [KW-1:0]      col_d;
    logic [KW-1:0]      k_cfg;

    logic [P-1:0]       act_ext;
    logic [P-1:0]       prod [NP];
    logic [P-1:0]       s_chain [SN];
    logic [P-1:0]       result;

    logic               accept;
    logic               push;
    logic               short_hit;
    logic               clr;
    logic [CW-1:0]      fifo_count;

    function automatic logic [P-1:0] chain_add(input logic [P-1:0] a, input logic [P-1:0] b);
`ifdef PE_SATURATE_EN
        logic [P:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (signed_q) begin
            // Overflow only when both operands share a sign the sum does not.
            if ((a[P-1] == b[P-1]) && (sum[P-1] != a[P-1])) begin
                return a[P-1] ? {1'b1, {(P-1){1'b0}}} : {1'b0, {(P-1){1'b1}}};
            end
            return sum[P-1:0];
        end
        return sum[P] ? {P{1'b1}} : sum[P-1:0];
`else
        return a + b;
`endif
    endfunction

    // Handshake, row bookkeeping and kernel-size sanitising.
    always_comb begin
        act_ready_o = (state_q == StRun) && (fifo_count < CW'(FIFO_DEPTH));
        accept      = act_valid_i && act_ready_o;
        push        = accept && (col_q >= (k_q - KW'(1)));
        short_hit   = accept && act_last_i && (col_q < (k_q - KW'(1)));
        clr         = (accept && act_last_i) ||
                      ((state_q == StRun) && stop_i) ||
                      ((state_q == StIdle) && start_i);
        if (cfg_k_i == '0) begin
            k_cfg = KW'(1);
        end else if (cfg_k_i > KW'(KMAX)) begin
            k_cfg = KW'(KMAX);
        end else begin
            k_cfg = cfg_k_i;
        end
        act_ext = {{(P-A){signed_q & act_data_i[A-1]}}, act_data_i};
    end

    // One product per tap; padding entries read as zero.
    for (genvar j = 0; j < NP; j++) begin : g_prod
        if (j < KMAX) begin : g_tap
            logic [P-1:0] w_ext;
            assign w_ext   = {{(P-W){signed_q & w_q[j*W+W-1]}}, w_q[j*W +: W]};
            assign prod[j] = act_ext * w_ext;
        end else begin : g_pad
            assign prod[j] = '0;
        end
    end

    // Transposed partial-sum chain; stage i is fed by stage i+1 plus tap K-2-i.
    for (genvar i = 0; i < SN; i++) begin : g_chain
        logic [P-1:0] s_q;
        logic [P-1:0] s_d;
        logic [P-1:0] upper;

        if (i + 1 < SN) begin : g_up
            assign upper = s_chain[i+1];
        end else begin : g_end
            assign upper = '0;
        end

        // Next partial sum for this stage.
        always_comb begin
            s_d = s_q;
            if (clr) begin
                s_d = '0;
            end else if (accept) begin
                if ((i + 2) < int'(k_q)) begin
                    s_d = chain_add(upper, prod[k_q - KW'(i + 2)]);
                end else if ((i + 2) == int'(k_q)) begin
                    s_d = prod[0];
                end else begin
                    s_d = '0;
                end
            end
        end

        // Partial-sum register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= '0;
            end else begin
                s_q <= s_d;
            end
        end

        assign s_chain[i] = s_q;
    end

    // Output of the chain head; K=1 bypasses the chain entirely.
    always_comb begin
        if (k_q == KW'(1)) begin
            result = prod[0];
        end else begin
            result = chain_add(s_chain[0], prod[k_q - KW'(1)]);
        end
        col_d = col_q;
        if (clr) begin
            col_d = '0;
        end else if (accept && (col_q < KW'(KMAX))) begin
            col_d = col_q + KW'(1);
        end
    end

    // Column counter; saturates once the kernel is primed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
        end else begin
            col_q <= col_d;
        end
    end

    // Control FSM with its configuration and sticky status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            k_q         <= KW'(1);
            signed_q    <= 1'b0;
            w_q         <= '0;
            short_row_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (w_load_i) begin
                        w_q <= w_data_i;
                    end
                    if (start_i) begin
                        state_q     <= StRun;
                        k_q         <= k_cfg;
                        signed_q    <= cfg_signed_i;
                        short_row_q <= 1'b0;
                    end
                end
                StRun: begin
                    if (short_hit) begin
                        short_row_q <= 1'b1;
                    end
                    if (stop_i) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (fifo_count == '0) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    pe_out_fifo #(
        .WIDTH (P + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i ({act_last_i, result}),
        .pop_i   (out_ready_i),
        .rdata_o ({out_last_o, out_data_o}),
        .valid_o (out_valid_o),
        .count_o (fifo_count)
    );

    assign fifo_count_o = fifo_count;
    assign busy_o       = (state_q != StIdle);
    assign short_row_o  = short_row_q;

endmodule

// File: tb/tb_pe_row_conv.sv
// Scoreboard bench for pe_row_conv (KMAX=5, 8x8 operands, 16-bit psum, 4-entry FIFO).
module tb_pe_row_conv;

    localparam int unsigned KMAX = 5;
    localparam int unsigned PW   = 16;
    localparam int unsigned FD   = 4;

`ifdef PE_SATURATE_EN
    localparam logic [PW-1:0] SAT_EXP = 16'd32767;
`else
    localparam logic [PW-1:0] SAT_EXP = 16'd15109;
`endif

    typedef struct packed {
        logic [PW-1:0] d;
        logic          l;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, stop, cfg_signed, w_load;
    logic [2:0]        cfg_k;
    logic [KMAX*8-1:0] w_data;
    logic              act_valid, act_ready, act_last;
    logic [7:0]        act_data;
    logic              out_valid, out_ready, out_last;
    logic [PW-1:0]     out_data;
    logic              busy, short_row;
    logic [2:0]        fifo_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    pe_row_conv #(
        .KMAX       (KMAX),
        .ACT_WIDTH  (8),
        .W_WIDTH    (8),
        .PSUM_WIDTH (PW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .stop_i       (stop),
        .cfg_k_i      (cfg_k),
        .cfg_signed_i (cfg_signed),
        .w_load_i     (w_load),
        .w_data_i     (w_data),
        .act_valid_i  (act_valid),
        .act_ready_o  (act_ready),
        .act_data_i   (act_data),
        .act_last_i   (act_last),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_last_o   (out_last),
        .busy_o       (busy),
        .short_row_o  (short_row),
        .fifo_count_o (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Monitor: every output handshake is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: got %0h expected none", out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(e.d));
                chk("out_last", 32'(out_last), 32'(e.l));
            end
        end
    end

    task automatic expect_out(input logic [PW-1:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        sb.push_back(e);
    endtask

    task automatic send(input logic [7:0] x, input logic last);
        int n;
        n         = 0;
        act_data  = x;
        act_last  = last;
        act_valid = 1'b1;
        @(negedge clk);
        while (!act_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!act_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got act_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        act_valid = 1'b0;
        act_last  = 1'b0;
    endtask

    // Weights and start in the same cycle: weights must be the ones used in RUN.
    task automatic begin_run(input logic [2:0] k, input logic sgn, input logic [KMAX*8-1:0] w);
        w_load     = 1'b1;
        w_data     = w;
        start      = 1'b1;
        cfg_k      = k;
        cfg_signed = sgn;
        @(posedge clk);
        #1;
        w_load = 1'b0;
        start  = 1'b0;
    endtask

    task automatic end_run();
        int n;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop      = 1'b0;
        out_ready = 1'b1;
        n         = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_to_idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        cfg_k      = 3'd1;
        cfg_signed = 1'b0;
        w_load     = 1'b0;
        w_data     = '0;
        act_valid  = 1'b0;
        act_data   = '0;
        act_last   = 1'b0;
        out_ready  = 1'b1;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_act_ready", 32'(act_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(1);

        // K=3 unsigned, w={1,2,3}: row 1,2,3,4 -> 14, 20(last).
        begin_run(3'd3, 1'b0, {8'd0, 8'd0, 8'd3, 8'd2, 8'd1});
        chk("run_busy", 32'(busy), 32'd1);
        expect_out(16'd14, 1'b0);
        expect_out(16'd20, 1'b1);
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        chk("lat_not_primed", 32'(out_valid), 32'd0);
        send(8'd3, 1'b0);
        chk("lat_one_cycle", 32'(out_valid), 32'd1);
        send(8'd4, 1'b1);
        idle_cycles(3);
        chk("k3_short_row", 32'(short_row), 32'd0);
        end_run();

        // K=1 signed, w0=-2: 5, -3 -> -10, 6.
        begin_run(3'd1, 1'b1, {32'd0, 8'hFE});
        expect_out(16'hFFF6, 1'b0);
        expect_out(16'd6, 1'b1);
        send(8'd5, 1'b0);
        send(8'hFD, 1'b1);
        end_run();

        // FIFO backpressure: 4 accepts fill it, then drain and accept 2 more.
        begin_run(3'd1, 1'b0, {32'd0, 8'd1});
        out_ready = 1'b0;
        for (int v = 11; v <= 16; v++) begin
            expect_out(PW'(v), (v == 16));
        end
        for (int v = 11; v <= 14; v++) begin
            send(8'(v), 1'b0);
        end
        act_valid = 1'b1;
        act_data  = 8'd15;
        idle_cycles(2);
        chk("full_act_ready", 32'(act_ready), 32'd0);
        chk("full_count", 32'(fifo_count), 32'd4);
        act_valid = 1'b0;
        out_ready = 1'b1;
        send(8'd15, 1'b0);
        send(8'd16, 1'b1);
        end_run();

        // K=5 signed, all taps 127, x=127 x5: wraps or clamps at 16 bits.
        begin_run(3'd5, 1'b1, {5{8'd127}});
        expect_out(SAT_EXP, 1'b1);
        for (int n = 0; n < 4; n++) begin
            send(8'd127, 1'b0);
        end
        send(8'd127, 1'b1);
        end_run();

        // Short row: K=3 with only 2 activations.
        begin_run(3'd3, 1'b0, {8'd0, 8'd0, 8'd3, 8'd2, 8'd1});
        send(8'd1, 1'b0);
        send(8'd2, 1'b1);
        idle_cycles(2);
        chk("short_row_set", 32'(short_row), 32'd1);
        chk("short_no_output", 32'(fifo_count), 32'd0);
        end_run();
        chk("short_row_sticky", 32'(short_row), 32'd1);
        begin_run(3'd3, 1'b0, {8'd0, 8'd0, 8'd3, 8'd2, 8'd1});
        chk("short_row_cleared", 32'(short_row), 32'd0);
        end_run();

        // Stop mid-row with 2 pending: K=2, w={1,1}, 3,4,5 -> 7, 9.
        begin_run(3'd2, 1'b0, {24'd0, 8'd1, 8'd1});
        out_ready = 1'b0;
        expect_out(16'd7, 1'b0);
        expect_out(16'd9, 1'b0);
        send(8'd3, 1'b0);
        send(8'd4, 1'b0);
        send(8'd5, 1'b0);
        chk("stop_pending", 32'(fifo_count), 32'd2);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        chk("drain_busy", 32'(busy), 32'd1);
        chk("drain_not_ready", 32'(act_ready), 32'd0);
        end_run();
        chk("drain_delivered", 32'(sb.size()), 32'd0);

        // Reset mid-RUN with a pending entry.
        begin_run(3'd1, 1'b0, {32'd0, 8'd1});
        out_ready = 1'b0;
        send(8'd9, 1'b1);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_act_ready", 32'(act_ready), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_out_last", 32'(out_last), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_fifo_count", 32'(fifo_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle_cycles(3);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
